mem_ctrl: RTL and testbench

- Sits between the CPU's instruction-fetch unit (IF) and load/store unit (LSU) and the single byte-wide system memory bus: mem_a / mem_dout / mem_wr out, mem_din in.
- Arbitrates between the two requesters and serializes each 1/2/4-byte access into little-endian byte cycles.
- Tracks the one-cycle registered RAM read latency.
- Honours the bus-pause (rdy_in) and I/O back-pressure (io_buffer_full_in) signals.

---
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Requester and byte-bus signals of the memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_ctrl_if;
    logic        rdy_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        flush_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ls_req_in;
    logic        ls_we_in;
    logic [31:0] ls_addr_in;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] ls_rdata_out;
    logic [7:0]  mem_din_in;
    logic [7:0]  mem_dout_out;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;
    logic        io_buffer_full_in;
    logic        busy_out;

    modport slave (
        input  rdy_in, if_req_in, if_addr_in, flush_in,
        input  ls_req_in, ls_we_in, ls_addr_in, ls_size_in, ls_wdata_in,
        input  mem_din_in, io_buffer_full_in,
        output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
        output mem_dout_out, mem_a_out, mem_wr_out, busy_out
    );

    modport master (
        output rdy_in, if_req_in, if_addr_in, flush_in,
        output ls_req_in, ls_we_in, ls_addr_in, ls_size_in, ls_wdata_in,
        output mem_din_in, io_buffer_full_in,
        input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
        input  mem_dout_out, mem_a_out, mem_wr_out, busy_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF and LSU requests onto a byte-wide bus, serializing each access
// into little-endian byte cycles with a one-cycle registered read latency.
module mem_ctrl #(
    parameter int IO_SEL_HI = 17
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    mem_ctrl_if.slave bus
);
    // state    | meaning
    // S_IDLE   | waiting for a request, LSU has priority
    // S_IF_RD  | instruction word read in progress (flushable)
    // S_LS_RD  | LSU load in progress
    // S_LS_WR  | LSU store in progress
    // S_DONE   | one-cycle completion, done pulse high
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IF_RD = 3'd1,
        S_LS_RD = 3'd2,
        S_LS_WR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_a_last;
    logic [31:0] r_rbuf;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;
    logic [2:0]  r_n;
    logic [2:0]  r_i;
    logic [2:0]  r_c;
    logic        r_pend;
    logic        r_if_done;
    logic        r_ls_done;

    logic        w_xfer;
    logic        w_flush;
    logic        w_is_io;
    logic        w_issue;
    logic        w_wr_issue;
    logic        w_complete;
    logic        w_go_done;
    logic [31:0] w_addr;
    logic [31:0] w_rbuf_next;
    logic [2:0]  w_i_next;
    logic [2:0]  w_c_next;
    logic [2:0]  w_ls_n;
    logic [7:0]  w_wbyte;

    assign w_xfer  = (r_state == S_IF_RD) || (r_state == S_LS_RD) || (r_state == S_LS_WR);
    assign w_flush = (r_state == S_IF_RD) && bus.flush_in;
    assign w_addr  = r_base + {29'd0, r_i};
    assign w_is_io = (w_addr[IO_SEL_HI:IO_SEL_HI-1] == 2'b11);

    // Store stalls only for I/O targets while the output buffer is full.
    assign w_issue = w_xfer && bus.rdy_in && !w_flush && (r_i < r_n) &&
                     !((r_state == S_LS_WR) && w_is_io && bus.io_buffer_full_in);
    assign w_wr_issue = w_issue && (r_state == S_LS_WR);

    assign w_i_next = r_i + {2'd0, w_issue};
    assign w_c_next = r_c + {2'd0, r_pend};
    assign w_wbyte  = r_wdata[{r_i[1:0], 3'b000} +: 8];
    assign w_ls_n   = (bus.ls_size_in == 2'b00) ? 3'd1 :
                      (bus.ls_size_in == 2'b01) ? 3'd2 : 3'd4;

    always_comb begin
        w_rbuf_next = r_rbuf;
        if (r_pend) begin
            w_rbuf_next[{r_c[1:0], 3'b000} +: 8] = bus.mem_din_in;
        end
    end

    assign w_complete = (r_state == S_LS_WR) ? (w_i_next == r_n) : (w_c_next == r_n);
    assign w_go_done  = w_xfer && !w_flush && bus.rdy_in && w_complete;

    assign bus.mem_a_out    = w_issue ? w_addr : (w_xfer ? r_a_last : 32'd0);
    assign bus.mem_wr_out   = w_wr_issue;
    assign bus.mem_dout_out = w_wr_issue ? w_wbyte : 8'd0;
    assign bus.busy_out     = (r_state != S_IDLE);
    assign bus.if_done_out  = r_if_done;
    assign bus.if_data_out  = r_if_data;
    assign bus.ls_done_out  = r_ls_done;
    assign bus.ls_rdata_out = r_ls_rdata;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_base     <= 32'd0;
            r_wdata    <= 32'd0;
            r_a_last   <= 32'd0;
            r_rbuf     <= 32'd0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
            r_n        <= 3'd0;
            r_i        <= 3'd0;
            r_c        <= 3'd0;
            r_pend     <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_a_last <= 32'd0;
                    r_rbuf   <= 32'd0;
                    r_i      <= 3'd0;
                    r_c      <= 3'd0;
                    r_pend   <= 1'b0;
                    if (bus.rdy_in) begin
                        if (bus.ls_req_in) begin
                            r_base  <= bus.ls_addr_in;
                            r_wdata <= bus.ls_wdata_in;
                            r_n     <= w_ls_n;
                            r_state <= bus.ls_we_in ? S_LS_WR : S_LS_RD;
                        end else if (bus.if_req_in) begin
                            r_base  <= bus.if_addr_in;
                            r_n     <= 3'd4;
                            r_state <= S_IF_RD;
                        end
                    end
                end
                S_IF_RD, S_LS_RD, S_LS_WR: begin
                    if (w_flush) begin
                        r_pend  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_i    <= w_i_next;
                        r_c    <= w_c_next;
                        r_rbuf <= w_rbuf_next;
                        r_pend <= w_issue && (r_state != S_LS_WR);
                        if (w_issue) begin
                            r_a_last <= w_addr;
                        end
                        if (w_go_done) begin
                            r_state <= S_DONE;
                            if (r_state == S_IF_RD) begin
                                r_if_data <= w_rbuf_next;
                                r_if_done <= 1'b1;
                            end else if (r_state == S_LS_RD) begin
                                r_ls_rdata <= w_rbuf_next;
                                r_ls_done  <= 1'b1;
                            end else begin
                                r_ls_done <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-RAM model, done/result scoreboard and
// per-cycle bus checks.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    mem_ctrl_if bus();

    mem_ctrl #(.IO_SEL_HI(17)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mem [logic [31:0]];
    logic [7:0]  rd_next = 8'h00;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          w0;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_if, input bit cd, input logic [31:0] d);
        exp_t e;
        e.is_if = is_if;
        e.chk_data = cd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk_in);
        @(negedge clk_in);
        chk(tag, exp_q.size(), 32'd0);
    endtask

    // RAM model: address sampled mid-cycle, data presented after the next edge.
    always @(negedge clk_in) begin
        #2;
        if (bus.mem_wr_out) begin
            mem[bus.mem_a_out] = bus.mem_dout_out;
            n_wr++;
        end
        rd_next = rd(bus.mem_a_out);
        if (bus.if_done_out || bus.ls_done_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {30'd0, bus.if_done_out, bus.ls_done_out}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_port", {31'd0, bus.if_done_out}, {31'd0, mon_e.is_if});
                if (mon_e.chk_data)
                    chk("result", mon_e.is_if ? bus.if_data_out : bus.ls_rdata_out, mon_e.data);
            end
        end
    end

    always @(posedge clk_in) bus.mem_din_in <= rd_next;

    initial begin
        bus.rdy_in = 1'b1;
        bus.if_req_in = 1'b0;
        bus.if_addr_in = 32'd0;
        bus.flush_in = 1'b0;
        bus.ls_req_in = 1'b0;
        bus.ls_we_in = 1'b0;
        bus.ls_addr_in = 32'd0;
        bus.ls_size_in = 2'b00;
        bus.ls_wdata_in = 32'd0;
        bus.io_buffer_full_in = 1'b0;
        mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05;
        mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
        mem[32'h1004] = 8'h93; mem[32'h1005] = 8'h02;
        mem[32'h1006] = 8'h10; mem[32'h1007] = 8'h00;
        mem[32'h2002] = 8'hAB; mem[32'h2003] = 8'hCD;

        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_if_done", {31'd0, bus.if_done_out}, 32'd0);
        chk("rst_ls_done", {31'd0, bus.ls_done_out}, 32'd0);
        chk("rst_if_data", bus.if_data_out, 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata_out, 32'd0);
        chk("rst_mem_a", bus.mem_a_out, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr_out}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Word IF read at 0x1000
        @(negedge clk_in);
        bus.if_req_in = 1'b1;
        bus.if_addr_in = 32'h1000;
        push_exp(1'b1, 1'b1, 32'h0000_0513);
        #1 chk("t1_idle_a", bus.mem_a_out, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            if (k == 1) bus.if_req_in = 1'b0;
            #1;
            if (k <= 4) chk($sformatf("t1_addr%0d", k), bus.mem_a_out, 32'h1000 + k - 1);
            if (k == 5) chk("t1_addr_hold", bus.mem_a_out, 32'h1003);
            chk($sformatf("t1_wr%0d", k), {31'd0, bus.mem_wr_out}, 32'd0);
            chk($sformatf("t1_done%0d", k), {31'd0, bus.if_done_out}, (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) chk("t1_data", bus.if_data_out, 32'h0000_0513);
            if (k == 7) chk("t1_idle_busy", {31'd0, bus.busy_out}, 32'd0);
        end
        drain("t1_drain");

        // Simultaneous requests: LSU half load wins, IF follows after the bubble
        @(negedge clk_in);
        bus.if_req_in = 1'b1;
        bus.if_addr_in = 32'h1004;
        bus.ls_req_in = 1'b1;
        bus.ls_we_in = 1'b0;
        bus.ls_addr_in = 32'h2002;
        bus.ls_size_in = 2'b01;
        push_exp(1'b0, 1'b1, 32'h0000_CDAB);
        push_exp(1'b1, 1'b1, 32'h0010_0293);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            if (k == 1) bus.ls_req_in = 1'b0;
            if (k == 6) bus.if_req_in = 1'b0;
            #1;
            if (k == 1) chk("t2_addr1", bus.mem_a_out, 32'h2002);
            if (k == 2) chk("t2_addr2", bus.mem_a_out, 32'h2003);
            if (k == 4) chk("t2_ls_done", {31'd0, bus.ls_done_out}, 32'd1);
            if (k == 4) chk("t2_no_if_done", {31'd0, bus.if_done_out}, 32'd0);
            if (k == 5) chk("t2_bubble", {31'd0, bus.busy_out}, 32'd0);
            if (k == 6) chk("t2_if_start", bus.mem_a_out, 32'h1004);
        end
        drain("t2_drain");

        // I/O store byte with the output buffer full for 5 cycles
        w0 = n_wr;
        @(negedge clk_in);
        bus.ls_req_in = 1'b1;
        bus.ls_we_in = 1'b1;
        bus.ls_addr_in = 32'h0003_0000;
        bus.ls_size_in = 2'b00;
        bus.ls_wdata_in = 32'hAABB_CC41;
        bus.io_buffer_full_in = 1'b1;
        push_exp(1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (k == 1) bus.ls_req_in = 1'b0;
            if (k == 6) bus.io_buffer_full_in = 1'b0;
            #1;
            if (k <= 5) chk($sformatf("t3_stall%0d", k), {31'd0, bus.mem_wr_out}, 32'd0);
            if (k == 6) begin
                chk("t3_wr", {31'd0, bus.mem_wr_out}, 32'd1);
                chk("t3_dout", {24'd0, bus.mem_dout_out}, 32'h41);
                chk("t3_addr", bus.mem_a_out, 32'h0003_0000);
            end
            if (k == 7) chk("t3_done", {31'd0, bus.ls_done_out}, 32'd1);
            if (k == 8) chk("t3_wr_count", n_wr - w0, 32'd1);
        end
        chk("t3_mem", {24'd0, rd(32'h0003_0000)}, 32'h41);
        bus.ls_we_in = 1'b0;
        drain("t3_drain");

        // Word read with rdy_in low for 3 cycles after byte 1 is issued
        @(negedge clk_in);
        bus.if_req_in = 1'b1;
        bus.if_addr_in = 32'h1000;
        push_exp(1'b1, 1'b1, 32'h0000_0513);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_in);
            if (k == 1) bus.if_req_in = 1'b0;
            bus.rdy_in = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            #1;
            case (k)
                1: chk("t4_a1", bus.mem_a_out, 32'h1000);
                2: chk("t4_a2", bus.mem_a_out, 32'h1001);
                3, 4, 5: chk($sformatf("t4_hold%0d", k), bus.mem_a_out, 32'h1001);
                6: chk("t4_a6", bus.mem_a_out, 32'h1002);
                7: chk("t4_a7", bus.mem_a_out, 32'h1003);
                default: ;
            endcase
            chk($sformatf("t4_done%0d", k), {31'd0, bus.if_done_out}, (k == 9) ? 32'd1 : 32'd0);
        end
        drain("t4_drain");

        // Flush of an IF read in its third cycle
        w0 = n_wr;
        @(negedge clk_in);
        bus.if_req_in = 1'b1;
        bus.if_addr_in = 32'h1004;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (k == 1) bus.if_req_in = 1'b0;
            bus.flush_in = (k == 3);
            #1;
            if (k == 2) chk("t5_a2", bus.mem_a_out, 32'h1005);
            if (k == 4) chk("t5_idle", {31'd0, bus.busy_out}, 32'd0);
            if (k >= 3) chk($sformatf("t5_nodone%0d", k), {31'd0, bus.if_done_out}, 32'd0);
        end
        chk("t5_no_write", n_wr - w0, 32'd0);
        chk("t5_data_kept", bus.if_data_out, 32'h0000_0513);

        // Reset in the middle of a word store, then a fresh fetch
        @(negedge clk_in);
        bus.ls_req_in = 1'b1;
        bus.ls_we_in = 1'b1;
        bus.ls_addr_in = 32'h4000;
        bus.ls_size_in = 2'b10;
        bus.ls_wdata_in = 32'h1122_3344;
        @(negedge clk_in);
        bus.ls_req_in = 1'b0;
        #1;
        chk("t6_wr", {31'd0, bus.mem_wr_out}, 32'd1);
        chk("t6_dout", {24'd0, bus.mem_dout_out}, 32'h44);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("t6_rst_wr", {31'd0, bus.mem_wr_out}, 32'd0);
        chk("t6_rst_a", bus.mem_a_out, 32'd0);
        chk("t6_rst_dout", {24'd0, bus.mem_dout_out}, 32'd0);
        chk("t6_rst_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("t6_rst_if_data", bus.if_data_out, 32'd0);
        chk("t6_rst_ls_rdata", bus.ls_rdata_out, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        bus.ls_we_in = 1'b0;
        @(negedge clk_in);
        bus.if_req_in = 1'b1;
        bus.if_addr_in = 32'h1000;
        push_exp(1'b1, 1'b1, 32'h0000_0513);
        @(negedge clk_in);
        bus.if_req_in = 1'b0;
        drain("t6_drain");
        repeat (4) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
